// File: rtl/mpi_bus_pkg.sv
// Shared definitions for the MPI register responder: FSM states, default
// register addresses and byte-lane encodings.
package mpi_bus_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ADDR_A_DEF = 16'o177714;
  localparam logic [DATA_W-1:0] ADDR_B_DEF = 16'o177716;

  // Address bit 0 selects which byte of the word a byte write lands on.
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    READ,
    WRITE,
    HOLD,
    WAIT_END
  } mpi_state_e;

endpackage

// File: rtl/mpi_sync.sv
// Two-flop synchronizer for asynchronous bus strobes; resets to the inactive
// (high) level so nothing looks asserted coming out of reset.
module mpi_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '1;
      q       <= '1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/mpi_reg_responder.sv
// Two-register slave on the multiplexed, active-low MPI bus: decodes one
// address per register, serves word/byte writes and read replies.
module mpi_reg_responder
  import mpi_bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADDR_A = ADDR_A_DEF,
  parameter logic [DATA_W-1:0] ADDR_B = ADDR_B_DEF
) (
  input  logic              CLKp,
  input  logic              nRSTp,
  inout  wire  [DATA_W-1:0] nADp,
  input  logic              nSYNCp,
  input  logic              nWTBTp,
  input  logic              nDINp,
  input  logic              nDOUTp,
  output wire               nRPLYp,
  output logic              nSEL1p,
  output logic              nSEL2p,
  output logic [DATA_W-1:0] REGA,
  output logic [DATA_W-1:0] REGB,
  output logic              WRA,
  output logic              WRB
);

  mpi_state_e        state;
  logic [2:0]        strb_s;
  logic              sync_s, din_s, dout_s;
  logic              sync_prev, sync_seen;
  logic              sel_b, lane, wr_cyc;
  logic              ad_oe, rply;
  logic              capture, hit_a, hit_b, release_cyc;
  logic [DATA_W-1:0] bus_in, reg_sel;

  function automatic logic [DATA_W-1:0] merge_write(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic              byte_wr,
    input logic              lane_sel
  );
    logic [DATA_W-1:0] res;
    res = new_val;
    if (byte_wr) begin
      res = old_val;
      case (lane_sel)
        LANE_LO: res[7:0]  = new_val[7:0];
        LANE_HI: res[15:8] = new_val[15:8];
        default: ;
      endcase
    end
    return res;
  endfunction

  mpi_sync #(.WIDTH(3)) u_sync (
    .clk   (CLKp),
    .rst_n (nRSTp),
    .d     ({nSYNCp, nDINp, nDOUTp}),
    .q     (strb_s)
  );

  assign sync_s  = strb_s[2];
  assign din_s   = strb_s[1];
  assign dout_s  = strb_s[0];

  assign bus_in  = ~nADp;
  assign capture = sync_prev & ~nSYNCp;
  assign hit_a   = (bus_in[15:1] == ADDR_A[15:1]);
  assign hit_b   = (bus_in[15:1] == ADDR_B[15:1]);
  // The synchronized nSYNCp still shows the previous idle level for a couple of
  // edges after capture, so only a high seen after a low ends the cycle.
  assign release_cyc = (state != IDLE) && sync_seen && sync_s;

  assign reg_sel = sel_b ? REGB : REGA;
  assign nADp    = ad_oe ? ~reg_sel : {DATA_W{1'bz}};
  assign nRPLYp  = rply ? 1'b0 : 1'bz;

  // Address phase: latched attributes of the current bus cycle
  always_ff @(posedge CLKp) begin
    if (state == IDLE && capture) begin
      lane   <= bus_in[0];
      wr_cyc <= ~nWTBTp;
      sel_b  <= ~hit_a;
    end
  end

  // Bus cycle FSM
  always_ff @(posedge CLKp or negedge nRSTp) begin
    if (!nRSTp) begin
      state     <= IDLE;
      sync_prev <= 1'b0;
      sync_seen <= 1'b0;
      ad_oe     <= 1'b0;
      rply      <= 1'b0;
      nSEL1p    <= 1'b1;
      nSEL2p    <= 1'b1;
      REGA      <= '0;
      REGB      <= '0;
      WRA       <= 1'b0;
      WRB       <= 1'b0;
    end else begin
      sync_prev <= nSYNCp;
      WRA       <= 1'b0;
      WRB       <= 1'b0;
      if (release_cyc) begin
        state     <= IDLE;
        sync_seen <= 1'b0;
        ad_oe     <= 1'b0;
        rply      <= 1'b0;
        nSEL1p    <= 1'b1;
        nSEL2p    <= 1'b1;
      end else begin
        if (state != IDLE && !sync_s) sync_seen <= 1'b1;
        case (state)
          IDLE: begin
            if (capture) begin
              if (hit_a) begin
                state  <= SEL;
                nSEL2p <= 1'b0;
              end else if (hit_b) begin
                state  <= SEL;
                nSEL1p <= 1'b0;
              end else begin
                state <= WAIT_END;
              end
            end
          end
          SEL: begin
            // Read wins when both strobes are low.
            if (!din_s) begin
              state <= READ;
              ad_oe <= 1'b1;
            end else if (!dout_s && wr_cyc) begin
              state <= WRITE;
              rply  <= 1'b1;
              if (sel_b) begin
                REGB <= merge_write(REGB, bus_in, ~nWTBTp, lane);
                WRB  <= 1'b1;
              end else begin
                REGA <= merge_write(REGA, bus_in, ~nWTBTp, lane);
                WRA  <= 1'b1;
              end
            end
          end
          READ: begin
            if (din_s) begin
              state <= HOLD;
              ad_oe <= 1'b0;
              rply  <= 1'b0;
            end else begin
              rply <= 1'b1;
            end
          end
          WRITE: begin
            if (dout_s) begin
              state <= HOLD;
              rply  <= 1'b0;
            end
          end
          HOLD: begin
            if (!sync_s) state <= SEL;
          end
          WAIT_END: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpi_reg_responder.sv
// Directed bench for mpi_reg_responder: drives whole bus cycles and checks
// every output each clock against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_mpi_reg_responder;

  localparam logic [15:0] A_ADDR  = 16'o177714;
  localparam logic [15:0] B_ADDR  = 16'o177716;
  localparam logic [15:0] BH_ADDR = 16'o177717;
  localparam logic [15:0] X_ADDR  = 16'o177700;
  localparam int K_RD = 0, K_WR = 1, K_BOTH = 2;

  logic        CLKp = 1'b0;
  logic        nRSTp = 1'b0;
  logic        nSYNCp = 1'b1, nWTBTp = 1'b1, nDINp = 1'b1, nDOUTp = 1'b1;
  tri1  [15:0] nADp;
  tri1         nRPLYp;
  logic        nSEL1p, nSEL2p, WRA, WRB;
  logic [15:0] REGA, REGB;

  logic        tb_ad_oe = 1'b0;
  logic [15:0] tb_ad = 16'hFFFF;
  assign nADp = tb_ad_oe ? tb_ad : 'z;

  // Model state: register contents and expected outputs after the next edge
  logic [15:0] m_a = 16'h0, m_b = 16'h0, exp_ad = 16'hFFFF;
  logic        exp_sel1 = 1'b1, exp_sel2 = 1'b1, exp_rply = 1'b1;
  logic        exp_wra = 1'b0, exp_wrb = 1'b0, chk_ad = 1'b1, chk_on = 1'b0;
  int          n_tests = 0, n_fail = 0;

  mpi_reg_responder dut (
    .CLKp   (CLKp),
    .nRSTp  (nRSTp),
    .nADp   (nADp),
    .nSYNCp (nSYNCp),
    .nWTBTp (nWTBTp),
    .nDINp  (nDINp),
    .nDOUTp (nDOUTp),
    .nRPLYp (nRPLYp),
    .nSEL1p (nSEL1p),
    .nSEL2p (nSEL2p),
    .REGA   (REGA),
    .REGB   (REGB),
    .WRA    (WRA),
    .WRB    (WRB)
  );

  always #5 CLKp = ~CLKp;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  always @(posedge CLKp) begin
    #1;
    if (chk_on) begin
      check("REGA", REGA, m_a);
      check("REGB", REGB, m_b);
      check("WRA", 16'(WRA), 16'(exp_wra));
      check("WRB", 16'(WRB), 16'(exp_wrb));
      check("nSEL1p", 16'(nSEL1p), 16'(exp_sel1));
      check("nSEL2p", 16'(nSEL2p), 16'(exp_sel2));
      check("nRPLYp", 16'(nRPLYp), 16'(exp_rply));
      if (chk_ad) check("nADp", nADp, exp_ad);
    end
  end

  function automatic logic [15:0] bus_write(input logic [15:0] old_v, input logic [15:0] d,
                                            input logic byte_wr, input logic hi);
    if (!byte_wr) return d;
    return hi ? {d[15:8], old_v[7:0]} : {old_v[15:8], d[7:0]};
  endfunction

  // One bus cycle, 16 clocks. Initiator timeline (cycle k, driven on the
  // falling edge): address k=0..3, nSYNCp low k=1..10, strobe low k=4..7.
  // Responder timeline after the k-th rising edge: select k=1..12, strobe seen
  // at k=6, read data k=6..9 with reply k=7..9, write reply k=6..9, pulse k=6.
  task automatic xfer(input logic [15:0] addr, input int kind, input logic [15:0] data,
                      input logic byte_wr, input int rst_at,
                      input logic lit_chk, input logic [15:0] lit_val);
    logic ha, hb, hit, aborted, strobe;
    ha  = (addr[15:1] == A_ADDR[15:1]);
    hb  = (addr[15:1] == B_ADDR[15:1]);
    hit = ha || hb;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLKp);
      aborted = (rst_at >= 0) && (k >= rst_at);
      strobe  = (k >= 4) && (k <= 7);
      nSYNCp  = !((k >= 1) && (k <= 10));
      nDINp   = !(strobe && kind != K_WR);
      nDOUTp  = !(strobe && kind != K_RD);
      if (k <= 3) begin
        tb_ad_oe = 1'b1; tb_ad = ~addr; nWTBTp = (kind == K_RD);
      end else if (kind == K_WR && k <= 7) begin
        tb_ad_oe = 1'b1; tb_ad = ~data; nWTBTp = !byte_wr;
      end else begin
        tb_ad_oe = 1'b0; nWTBTp = 1'b1;
      end

      exp_sel1 = 1'b1; exp_sel2 = 1'b1; exp_rply = 1'b1;
      exp_wra = 1'b0; exp_wrb = 1'b0; exp_ad = 16'hFFFF; chk_ad = !tb_ad_oe;
      if (aborted) begin
        if (k == rst_at) begin m_a = 16'h0; m_b = 16'h0; end
      end else if (hit) begin
        exp_sel2 = !(ha && k >= 1 && k <= 12);
        exp_sel1 = !(!ha && k >= 1 && k <= 12);
        if (kind != K_WR) begin
          if (k >= 6 && k <= 9) exp_ad = ~(ha ? m_a : m_b);
          if (k >= 7 && k <= 9) exp_rply = 1'b0;
        end else begin
          if (k == 6) begin
            if (ha) begin m_a = bus_write(m_a, data, byte_wr, addr[0]); exp_wra = 1'b1; end
            else    begin m_b = bus_write(m_b, data, byte_wr, addr[0]); exp_wrb = 1'b1; end
          end
          if (k >= 6 && k <= 9) exp_rply = 1'b0;
        end
      end

      if (rst_at >= 0 && k == rst_at) begin
        nRSTp = 1'b0;
        #1;
        check("rst_now_REGB", REGB, 16'h0000);
        check("rst_now_rply", 16'(nRPLYp), 16'h0001);
        check("rst_now_sel1", 16'(nSEL1p), 16'h0001);
      end
      if (rst_at >= 0 && k == rst_at + 1) nRSTp = 1'b1;
      if (lit_chk && k == 8) begin
        #1;
        check("lit_read_data", nADp, lit_val);
        check("lit_read_rply", 16'(nRPLYp), 16'h0000);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got timeout, want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLKp);
    check("reset_REGA", REGA, 16'h0000);
    check("reset_REGB", REGB, 16'h0000);
    check("reset_sel1", 16'(nSEL1p), 16'h0001);
    check("reset_sel2", 16'(nSEL2p), 16'h0001);
    check("reset_wr", 16'({WRA, WRB}), 16'h0000);
    check("reset_rply", 16'(nRPLYp), 16'h0001);
    check("reset_ad", nADp, 16'hFFFF);
    nRSTp  = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge CLKp);

    xfer(B_ADDR, K_WR, 16'h000F, 1'b0, -1, 1'b0, 16'h0);
    check("lit_word_write_B", REGB, 16'h000F);
    xfer(A_ADDR, K_WR, 16'hAAAA, 1'b0, -1, 1'b0, 16'h0);
    xfer(A_ADDR, K_WR, 16'h0055, 1'b1, -1, 1'b0, 16'h0);
    check("lit_byte_write_A", REGA, 16'hAA55);
    xfer(A_ADDR, K_RD, 16'h0, 1'b0, -1, 1'b1, 16'h55AA);
    xfer(B_ADDR, K_RD, 16'h0, 1'b0, -1, 1'b1, 16'hFFF0);
    xfer(X_ADDR, K_WR, 16'h1234, 1'b0, -1, 1'b0, 16'h0);
    check("lit_miss_A", REGA, 16'hAA55);
    check("lit_miss_B", REGB, 16'h000F);
    xfer(A_ADDR, K_BOTH, 16'h0, 1'b0, -1, 1'b1, 16'h55AA);
    check("lit_both_A", REGA, 16'hAA55);
    xfer(BH_ADDR, K_WR, 16'h5A00, 1'b1, -1, 1'b0, 16'h0);
    check("lit_byte_hi_B", REGB, 16'h5A0F);
    xfer(B_ADDR, K_WR, 16'hFFFF, 1'b0, 5, 1'b0, 16'h0);
    check("lit_after_rst_B", REGB, 16'h0000);
    xfer(A_ADDR, K_WR, 16'h1357, 1'b0, -1, 1'b0, 16'h0);
    xfer(A_ADDR, K_RD, 16'h0, 1'b0, -1, 1'b1, 16'hECA8);
    repeat (3) @(negedge CLKp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
